// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the 8-bit accumulator CPU and the bench of
// its external ALU.
//   ADDR_W / DATA_W : default memory-address and data widths
//   op_e            : 3-bit instruction opcode (IR[7:5])
//   state_e         : cpu_control sequencer states
// ST_STEP is used only when CPU_SINGLE_STEP_EN is defined.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPER   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_STORE  = 3'd5,
    ST_HALT   = 3'd6,
    ST_STEP   = 3'd7
  } state_e;

endpackage

// File: rtl/cpu_decode.sv
// ---------------------------------------------------------------------------
// cpu_decode
// Combinational instruction class decoder for cpu_control.
//   op            : opcode field IR[7:5]
//   needs_operand : ADD/AND/XOR/LDA read M[addr] into the MDR
//   is_store      : STO writes the accumulator to M[addr]
//   writes_acc    : instruction updates the accumulator in EXEC
//   is_jump       : JMP loads pc from the address field
//   is_skip       : SKZ conditionally skips the next instruction
//   is_halt       : HLT stops the sequencer
// ---------------------------------------------------------------------------
module cpu_decode (
  input  logic [2:0] op,
  output logic       needs_operand,
  output logic       is_store,
  output logic       writes_acc,
  output logic       is_jump,
  output logic       is_skip,
  output logic       is_halt
);
  import cpu_pkg::*;

  op_e op_q;
  assign op_q = op_e'(op);

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    needs_operand = 1'b0;
    is_store      = 1'b0;
    writes_acc    = 1'b0;
    is_jump       = 1'b0;
    is_skip       = 1'b0;
    is_halt       = 1'b0;
    unique case (op_q)
      OP_HLT:                         is_halt = 1'b1;
      OP_SKZ:                         is_skip = 1'b1;
      OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
        needs_operand = 1'b1;
        writes_acc    = 1'b1;
      end
      OP_STO:                         is_store = 1'b1;
      OP_JMP:                         is_jump  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// ---------------------------------------------------------------------------
// cpu_control
// Fetch/decode/execute sequencer of the 8-bit accumulator CPU. Holds pc, IR,
// accumulator and MDR, drives the external ALU and a req/ack memory port.
// Instruction format: {opcode[7:5], addr[4:0]}.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   start             : pulse, leaves IDLE or HALT
//   step              : (CPU_SINGLE_STEP_EN only) pulse, leaves STEP
//   mem_req/mem_we    : access request / write enable, held until accepted
//   mem_addr/mem_wdata: access address / write data (accumulator)
//   mem_rdata/mem_ack : read data / accept; access completes on req && ack
//   alu_rs1/alu_rs2   : accumulator / MDR
//   alu_opcode        : IR[7:5]
//   alu_rd/alu_is_zero: ALU result / accumulator-is-zero flag
//   halted, pc        : HALT indicator, program counter
//
// Configuration macro: CPU_SINGLE_STEP_EN adds the step port and the STEP
// state, entered after every instruction that does not halt.
// ---------------------------------------------------------------------------
module cpu_control #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_rd,
  input  logic              alu_is_zero,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);
  import cpu_pkg::*;

  // State entered once an instruction has retired.
`ifdef CPU_SINGLE_STEP_EN
  localparam state_e NEXT_INSN = ST_STEP;
`else
  localparam state_e NEXT_INSN = ST_FETCH;
`endif

  state_e            state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mdr;
  logic              accept;

  logic needs_operand, is_store, writes_acc, is_jump, is_skip, is_halt;

  cpu_decode u_decode (
    .op            (ir[DATA_W-1 -: 3]),
    .needs_operand (needs_operand),
    .is_store      (is_store),
    .writes_acc    (writes_acc),
    .is_jump       (is_jump),
    .is_skip       (is_skip),
    .is_halt       (is_halt)
  );

  assign accept = mem_req && mem_ack;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      acc   <= '0;
      mdr   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) state <= ST_FETCH;

        ST_FETCH: if (accept) begin
          ir    <= mem_rdata;
          pc    <= pc + 1'b1;  // wraps mod 2^ADDR_W
          state <= ST_DECODE;
        end

        ST_DECODE: begin
          if (is_halt) begin
            state <= ST_HALT;
          end else if (is_jump) begin
            pc    <= ir[ADDR_W-1:0];
            state <= NEXT_INSN;
          end else if (is_skip) begin
            // pc already points past SKZ; one more increment skips the next.
            if (alu_is_zero) pc <= pc + 1'b1;
            state <= NEXT_INSN;
          end else if (needs_operand) begin
            state <= ST_OPER;
          end else if (is_store) begin
            state <= ST_STORE;
          end else begin
            state <= NEXT_INSN;
          end
        end

        ST_OPER: if (accept) begin
          mdr   <= mem_rdata;
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          if (writes_acc) acc <= alu_rd;
          state <= NEXT_INSN;
        end

        ST_STORE: if (accept) state <= NEXT_INSN;

        ST_HALT: if (start) state <= ST_FETCH;

`ifdef CPU_SINGLE_STEP_EN
        ST_STEP: if (step) state <= ST_FETCH;
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of registered state, IR, pc and acc: no
  // input reaches it combinationally, so a pending request cannot change
  // while the memory stalls.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      ST_OPER: begin
        mem_req  = 1'b1;
        mem_addr = ir[ADDR_W-1:0];
      end
      ST_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ir[ADDR_W-1:0];
        mem_wdata = acc;
      end
      default: ;
    endcase
  end

  assign alu_rs1    = acc;
  assign alu_rs2    = mdr;
  assign alu_opcode = ir[DATA_W-1 -: 3];
  assign halted     = (state == ST_HALT);

endmodule
